// File: rtl/calc_pkg.sv
// Shared types and codes for the calculator front-panel sequencer.
package calc_pkg;

  localparam int unsigned REG_CNT   = 4;
  localparam int unsigned REG_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPSEL   = 3'd1,
    ST_SIZESEL = 3'd2,
    ST_LOADA   = 3'd3,
    ST_LOADB   = 3'd4,
    ST_EXEC    = 3'd5,
    ST_WAIT    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  localparam logic [2:0] MODE_FP     = 3'b000;
  localparam logic [2:0] MODE_ARITH  = 3'b001;
  localparam logic [2:0] MODE_BITMAN = 3'b010;
  localparam logic [2:0] MODE_LOGIC  = 3'b011;
  localparam logic [2:0] MODE_FETCH  = 3'b100;
  localparam logic [2:0] MODE_STORE  = 3'b101;

  localparam logic [1:0] UNIT_FPU   = 2'b00;
  localparam logic [1:0] UNIT_ARITH = 2'b01;
  localparam logic [1:0] UNIT_MANIP = 2'b10;
  localparam logic [1:0] UNIT_LOGIC = 2'b11;

  localparam logic [2:0] OP_ARITH_LOG = 3'b100;
  localparam logic [2:0] OP_LOGIC_NOT = 3'b110;

  localparam logic [1:0] SIZE_16 = 2'b00;
  localparam logic [1:0] SIZE_32 = 2'b01;
  localparam logic [1:0] SIZE_64 = 2'b10;

  // Number of 16-bit entry words for an operand of the given size.
  function automatic logic [2:0] size_words(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_16: n = 3'd1;
      SIZE_32: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m <= MODE_STORE);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Sequencer-to-execution-unit bus: operation select, operands, issue and results.
interface calc_sequencer_if #(
  parameter int unsigned DATA_W = 64
);
  logic [1:0]        unit_sel;
  logic [2:0]        op_sel;
  logic [1:0]        rmode;
  logic [1:0]        size_sel;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              start;
  logic              fpu_ready;
  logic [DATA_W-1:0] fp_out;
  logic [DATA_W-1:0] calc_out;
  logic [DATA_W-1:0] manip_out;
  logic [DATA_W-1:0] logic_out;

  modport master (
    output unit_sel, op_sel, rmode, size_sel, opa, opb, start,
    input  fpu_ready, fp_out, calc_out, manip_out, logic_out
  );

  modport slave (
    input  unit_sel, op_sel, rmode, size_sel, opa, opb, start,
    output fpu_ready, fp_out, calc_out, manip_out, logic_out
  );
endinterface

// File: rtl/calc_regfile.sv
// 4-entry operand register file: one synchronous write port, one async read port.
module calc_regfile
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_idx,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic [DATA_W-1:0]    rd_data_c
);

  logic [DATA_W-1:0] mem [REG_CNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_idx];

endmodule

// File: rtl/calc_sequencer.sv
// Front-panel sequencer: mode/op/size/operand entry, unit issue, result latch.
// Optional FPU WAIT timeout enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned INT_LAT     = 1,
  parameter int unsigned FPU_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  input  logic [WORD_W-1:0]  switches,
  calc_sequencer_if.master   bus,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               sign,
  output logic               busy,
  output logic               timeout,
  output logic [2:0]         state_dbg
);

  localparam int unsigned NWORDS = DATA_W / WORD_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned LAT_W  = $clog2(INT_LAT + 1);

  if (INT_LAT < 1 || FPU_TIMEOUT < 1) begin : g_bad_cfg
    $error("calc_sequencer: INT_LAT and FPU_TIMEOUT must be at least 1");
  end

  state_t state, state_nx;

  logic [2:0]           mode_q;
  logic [2:0]           op_q;
  logic [1:0]           unit_q;
  logic [1:0]           rmode_q;
  logic [1:0]           size_q;
  logic [REG_IDX_W-1:0] idx_q;
  logic [DATA_W-1:0]    opa_q;
  logic [DATA_W-1:0]    opb_q;
  logic [IDX_W-1:0]     word_cnt;
  logic [LAT_W-1:0]     lat_cnt;
  logic                 start_q;

  logic              last_word_c;
  logic              skip_b_c;
  logic              lat_done_c;
  logic              tmo_hit_c;
  logic              wait_done_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_c;
  logic [DATA_W-1:0] res_nx_c;

  function automatic logic size_msb(input logic [1:0] size, input logic [DATA_W-1:0] v);
    logic b;
    case (size)
      SIZE_16: b = v[WORD_W-1];
      SIZE_32: b = v[2*WORD_W-1];
      default: b = v[DATA_W-1];
    endcase
    return b;
  endfunction

  assign last_word_c = (3'(word_cnt) == (size_words(size_q) - 3'd1));
  assign skip_b_c    = (mode_q == MODE_STORE) ||
                       ((mode_q == MODE_ARITH) && (op_q == OP_ARITH_LOG)) ||
                       ((mode_q == MODE_LOGIC) && (op_q == OP_LOGIC_NOT));
  assign lat_done_c  = (lat_cnt == LAT_W'(INT_LAT - 1));
  assign wait_done_c = (mode_q == MODE_FP) ? (bus.fpu_ready || tmo_hit_c) : lat_done_c;
  assign wr_en_c     = (state == ST_EXEC) && (mode_q == MODE_STORE);

  calc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_c),
    .wr_idx    (idx_q),
    .wr_data   (opa_q),
    .rd_idx    (idx_q),
    .rd_data_c (rd_data_c)
  );

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(FPU_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // FP WAIT cycle counter; restarts every time WAIT is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_WAIT) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit_c = (state == ST_WAIT) && (mode_q == MODE_FP) && !bus.fpu_ready &&
                     (tmo_cnt == TMO_W'(FPU_TIMEOUT - 1));

  // Sticky until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if (state_nx == ST_EXEC) begin
      timeout <= 1'b0;
    end else if (tmo_hit_c) begin
      timeout <= 1'b1;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (btn && mode_is_valid(switches[2:0])) state_nx = ST_OPSEL;
      ST_OPSEL:   if (btn) state_nx = ST_SIZESEL;
      ST_SIZESEL: if (btn) state_nx = (mode_q == MODE_FETCH) ? ST_EXEC : ST_LOADA;
      ST_LOADA:   if (btn && last_word_c) state_nx = skip_b_c ? ST_EXEC : ST_LOADB;
      ST_LOADB:   if (btn && last_word_c) state_nx = ST_EXEC;
      ST_EXEC:    state_nx = ((mode_q == MODE_FETCH) || (mode_q == MODE_STORE)) ? ST_DONE : ST_WAIT;
      ST_WAIT:    if (wait_done_c) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Result source by mode; a timed-out FP operation yields zero.
  always_comb begin
    res_nx_c = '0;
    case (mode_q)
      MODE_FP:     res_nx_c = bus.fp_out;
      MODE_ARITH:  res_nx_c = bus.calc_out;
      MODE_BITMAN: res_nx_c = bus.manip_out;
      MODE_LOGIC:  res_nx_c = bus.logic_out;
      MODE_FETCH:  res_nx_c = rd_data_c;
      MODE_STORE:  res_nx_c = opa_q;
      default:     res_nx_c = '0;
    endcase
    if (tmo_hit_c) begin
      res_nx_c = '0;
    end
  end

  // WAIT latency counter for the fixed-latency integer units.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (state == ST_WAIT) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end else begin
      lat_cnt <= '0;
    end
  end

  // Entry registers: captured from switches on btn in the entry states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= '0;
      op_q     <= '0;
      unit_q   <= '0;
      rmode_q  <= '0;
      size_q   <= '0;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      word_cnt <= '0;
    end else if (btn) begin
      case (state)
        ST_IDLE: begin
          if (mode_is_valid(switches[2:0])) begin
            mode_q <= switches[2:0];
            unit_q <= switches[2] ? UNIT_FPU : switches[1:0];
          end
        end
        ST_OPSEL: begin
          op_q <= switches[2:0];
          if (mode_q == MODE_FP) rmode_q <= switches[4:3];
          if ((mode_q == MODE_FETCH) || (mode_q == MODE_STORE)) idx_q <= switches[1:0];
        end
        ST_SIZESEL: begin
          size_q <= (switches[1:0] == 2'b11) ? SIZE_64 : switches[1:0];
          if (mode_q != MODE_FETCH) begin
            opa_q    <= '0;
            opb_q    <= '0;
            word_cnt <= '0;
          end
        end
        ST_LOADA: begin
          for (int unsigned w = 0; w < NWORDS; w++) begin
            if (word_cnt == IDX_W'(w)) opa_q[w*WORD_W +: WORD_W] <= switches;
          end
          word_cnt <= last_word_c ? '0 : word_cnt + IDX_W'(1);
        end
        ST_LOADB: begin
          for (int unsigned w = 0; w < NWORDS; w++) begin
            if (word_cnt == IDX_W'(w)) opb_q[w*WORD_W +: WORD_W] <= switches;
          end
          word_cnt <= last_word_c ? '0 : word_cnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      sign         <= 1'b0;
    end else begin
      start_q      <= (state_nx == ST_EXEC);
      busy         <= (state_nx == ST_EXEC) || (state_nx == ST_WAIT);
      result_valid <= (state_nx == ST_DONE);
      if (state_nx == ST_DONE) begin
        result <= res_nx_c;
        sign   <= size_msb(size_q, res_nx_c);
      end
    end
  end

  assign bus.unit_sel = unit_q;
  assign bus.op_sel   = op_q;
  assign bus.rmode    = rmode_q;
  assign bus.size_sel = size_q;
  assign bus.opa      = opa_q;
  assign bus.opb      = opb_q;
  assign bus.start    = start_q;
  assign state_dbg    = state;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Front-panel sequencer for the calculator datapath. It walks the user through mode, operation, size and operand entry with a debounced button and 16 switches. It assembles 64-bit operands from 16-bit words and issues a one-cycle start to the selected unit (FPU, integer arithmetic, bit manipulation or logic). It waits for completion, then latches the result and sign; store and fetch modes use a 4×64 register file.

## Interface
- `WORD_W`, 16: switch word width.
- `DATA_W`, 64: operand/result width.
- `INT_LAT`, 1: fixed latency in cycles of the integer units, ≥1.
- `FPU_TIMEOUT`, 255: WAIT-cycle limit for FPU `ready`; used only with the timeout feature.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `btn`, input, 1: one-cycle debounced press strobe.
- `switches`, input, 16: entry value.
- `unit_sel`, output, 2: 00 FPU, 01 int arithmetic, 10 bit manip, 11 logic.
- `op_sel`, output, 3: operation code to the units.
- `rmode`, output, 2: FPU rounding mode.
- `size_sel`, output, 2: 00 16-bit, 01 32-bit, 10 64-bit.
- `opa`, `opb`, output, 64: operands.
- `start`, output, 1: one-cycle issue pulse.
- `fpu_ready`, input, 1: FPU completion.
- `fp_out`, `calc_out`, `manip_out`, `logic_out`, input, 64: unit results.
- `result`, output, 64: latched result.
- `result_valid`, output, 1: one-cycle pulse.
- `sign`, output, 1: MSB of `result` at the selected size.
- `busy`, output, 1: high in EXEC and WAIT.
- `timeout`, output, 1: FPU timeout flag.
- `state_dbg`, output, 3: current state.

## Operation
- Reset (async, `rst`=0) values:
  - state IDLE.
  - All outputs 0.
  - Register file cleared.
  - Word counter 0.
- States and transitions; `btn` acts only where stated and is ignored in EXEC, WAIT and DONE.
  - IDLE: on `btn`, mode ← `switches[2:0]`. Modes are 000 FP, 001 arith, 010 bitman, 011 logic, 100 fetch, 101 store. Codes 110/111 are ignored and the state stays in IDLE. A valid mode goes to OPSEL.
  - OPSEL: on `btn`, `op_sel` ← `switches[2:0]`. FP mode also sets `rmode` ← `switches[4:3]`. Fetch/store modes set reg index ← `switches[1:0]`. Next state is SIZESEL.
  - SIZESEL: on `btn`, `size_sel` ← `switches[1:0]`, with 11 stored as 10. Word count N = 1, 2 or 4. Fetch goes to EXEC; every other mode goes to LOADA, which clears `opa`/`opb` and the counter.
  - LOADA: each `btn` writes `opa[16k +: 16]` ← `switches` and increments k. After word N the state goes to LOADB, or to EXEC when the operation is unary or the mode is store. Unary operations are arith 100 (log) and logic 110 (not).
  - LOADB: same as LOADA, writing `opb`; after word N go to EXEC.
  - EXEC: `start`=1 for this one cycle. Store writes reg[idx] ← `opa`; fetch and store go to DONE. All other modes go to WAIT.
  - WAIT: FP mode exits on `fpu_ready`=1. Integer modes exit after `INT_LAT` cycles. Exit is to DONE.
  - DONE: `result_valid`=1, then return to IDLE.
- Unused upper operand words are zero. There is no sign extension.
- The result is latched on entry to DONE, by mode:
  - FP: `fp_out`.
  - Arith: `calc_out`.
  - Bitman: `manip_out`.
  - Logic: `logic_out`.
  - Fetch: reg[idx].
  - Store: `opa`.
- `sign` is `result[15]`, `[31]` or `[63]` according to `size_sel`, latched together with `result`.
- `result` holds until the next DONE.
- Reset mid-operation aborts immediately. No partial register write survives.

## Timing
- A `btn` in cycle t changes state at t+1. A `btn` in the same cycle as a state change applies to the old state only.
- `start` is issued at cycle e:
  - Integer units: `result_valid` at e+1+`INT_LAT`.
  - FPU: `fpu_ready` is sampled from e+1. Ready at cycle w gives `result_valid` at w+1. Ready at cycle e is ignored.
  - Fetch/store: `result_valid` at e+1.
- `opa`, `opb`, `op_sel`, `unit_sel`, `rmode` and `size_sel` stay stable from EXEC through DONE.

## Configuration
- `CALC_SEQ_TIMEOUT_EN` defined:
  - WAIT counts cycles in FP mode.
  - After `FPU_TIMEOUT` cycles without `fpu_ready`, go to DONE with `result`=0 and `sign`=0, and set `timeout`=1.
  - `timeout` is sticky until the next `start`.
- `CALC_SEQ_TIMEOUT_EN` undefined:
  - WAIT waits indefinitely.
  - `timeout` is tied to 0 and the counter is not built.

## Structure
- Package `calc_pkg` holds:
  - the state enum (IDLE, OPSEL, SIZESEL, LOADA, LOADB, EXEC, WAIT, DONE);
  - mode and unit codes;
  - the unary-operation codes;
  - a size→word-count function.
- One sub-module, `calc_regfile`: 4×64, one write port and one read port, async-clear on `rst`.

## Test plan
- Arith add, 16-bit: modes 001 / op 000 / size 00, A=0x0005, B=0x0003, `calc_out` model = A+B → `start` once, `result`=0x8, `result_valid` at e+2 (`INT_LAT`=1), `sign`=0.
- FP, 64-bit: 4 A words and 4 B words loaded LSW-first → `opa`=0x4000_0000_0000_0000. With `fpu_ready` 5 cycles after `start`, `result_valid` follows ready by one cycle.
- Unary logic not (011/110), 32-bit: after 2 A words the next state is EXEC with no LOADB, and `opb`=0.
- Store then fetch: store 0x1234 to reg 2 (16-bit), then fetch reg 2 → `result`=0x1234. Fetch of reg 3 → 0.
- Mode 111 in IDLE → state stays IDLE. A `btn` during WAIT is ignored. `rst` low in LOADB → all outputs 0 and IDLE immediately (async).
- With `CALC_SEQ_TIMEOUT_EN` and `FPU_TIMEOUT`=8, `fpu_ready` held low → DONE after 8 WAIT cycles, `timeout`=1, `result`=0. `timeout` clears on the next `start`.
